alu_op_sequencer: RTL and testbench

- Initiator-side front end for the ALU control unit.
- Accepts operation requests (op, operands) on a valid/ready handshake.
- Loads operands into the datapath, then drives start/op into the control unit. Holds start until the control unit leaves state 0.
- Waits for final, captures the datapath result and returns it on a valid/ready response channel, with timeout error reporting.

---
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Request/response front end for the ALU control unit: loads operands, starts the unit,
// waits for final (with timeout) and returns the result. Define ALU_SEQ_DIV0_CHECK_EN for early div-by-zero errors.
module alu_op_sequencer #(
  parameter int W              = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic           dp_ld,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  output logic           cu_start,
  output logic [1:0]     cu_op,
  input  logic [3:0]     cu_state,
  input  logic           cu_final,
  input  logic [2*W-1:0] dp_result,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_result,
  output logic [1:0]     rsp_op,
  output logic           rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RESP, DRAIN} state_t;

  state_t        state, next_state;
  logic [1:0]    op_q;
  logic [CW-1:0] cnt;
  logic          accept, div0, cap_ok, cap_err, cnt_clr;
  logic          cu_idle, timeout;

  assign cu_idle   = (cu_state == 4'd0);
  assign timeout   = (cnt == TO_LAST);
  assign cu_op     = op_q;
  assign rsp_valid = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    dp_ld      = 1'b0;
    cu_start   = 1'b0;
    accept     = 1'b0;
    div0       = 1'b0;
    cap_ok     = 1'b0;
    cap_err    = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = cu_idle;
        if (req_valid && cu_idle) begin
          accept     = 1'b1;
          next_state = LOAD;
`ifdef ALU_SEQ_DIV0_CHECK_EN
          if (req_op == 2'b11 && req_b == '0) begin
            div0       = 1'b1;
            next_state = RESP;
          end
`endif
        end
      end
      LOAD: begin
        dp_ld      = 1'b1;
        next_state = START;
      end
      START: begin
        // cu_start drops combinationally in the cycle the unit is seen leaving state 0.
        if (!cu_idle) begin
          cnt_clr    = 1'b1;
          next_state = RUN;
        end else begin
          cu_start = 1'b1;
          if (timeout) begin
            cap_err    = 1'b1;
            next_state = RESP;
          end
        end
      end
      RUN: begin
        if (cu_final) begin
          cap_ok     = 1'b1;
          next_state = RESP;
        end else if (timeout) begin
          cap_err    = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    if (rsp_ready) next_state = DRAIN;
      DRAIN:   if (cu_idle)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: operand and response registers are plain flops, so they all take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) op_q <= req_op;
      if (accept && !div0) begin
        dp_a <= req_a;
        dp_b <= req_b;
      end
      if (accept || cnt_clr)                 cnt <= '0;
      else if (state == START || state == RUN) cnt <= cnt + CW'(1);
      if (cap_ok) begin
        rsp_result <= dp_result;
        rsp_err    <= 1'b0;
        rsp_op     <= op_q;
      end else if (cap_err) begin
        rsp_result <= '0;
        rsp_err    <= 1'b1;
        rsp_op     <= op_q;
      end else if (div0) begin
        rsp_result <= '0;
        rsp_err    <= 1'b1;
        rsp_op     <= req_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural control-unit model.
module tb_alu_op_sequencer;

  localparam int W   = 8;
  localparam int TO  = 64;
  localparam int FIN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic          dp_ld;
  logic [W-1:0]  dp_a, dp_b;
  logic          cu_start;
  logic [1:0]    cu_op;
  logic [3:0]    cu_state;
  logic          cu_final;
  logic [15:0]   dp_result;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [15:0]   rsp_result;
  logic [1:0]    rsp_op;
  logic          rsp_err;

  int n_vec = 0;
  int n_bad = 0;

  alu_op_sequencer #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .dp_ld(dp_ld), .dp_a(dp_a), .dp_b(dp_b),
    .cu_start(cu_start), .cu_op(cu_op), .cu_state(cu_state), .cu_final(cu_final),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Control-unit model: leaves state 0 on start, raises final FIN cycles later with the
  // next queued result, then returns to 0 after m_hold extra cycles.
  logic [15:0] m_res_arr [8];
  logic [2:0]  m_wr = '0;
  logic [2:0]  m_rd;
  int          m_cnt;
  bit          m_hang  = 1'b0;
  bit          m_abort = 1'b0;
  int          m_hold  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cu_state  <= 4'd0;
      cu_final  <= 1'b0;
      dp_result <= '0;
      m_cnt     <= 0;
      m_rd      <= m_wr;
    end else begin
      cu_final <= 1'b0;
      if (cu_state == 4'd0) begin
        if (cu_start) begin
          cu_state <= 4'd1;
          m_cnt    <= 0;
        end
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_abort) cu_state <= 4'd0;
        else if (!m_hang) begin
          if (m_cnt == FIN - 1) begin
            cu_final  <= 1'b1;
            dp_result <= m_res_arr[m_rd];
            m_rd      <= m_rd + 3'd1;
            cu_state  <= 4'd5;
          end
          if (m_cnt == FIN + m_hold) cu_state <= 4'd0;
        end
      end
    end
  end

  // Edge monitor: pulse counts, response log, and edge stamps for latency checks.
  int          cyc = 0, n_ld = 0, n_start = 0, n_rsp = 0, t_fall = 0, t_rise = 0;
  bit          prev_start = 1'b0, prev_valid = 1'b0;
  logic [15:0] rq_res [$];
  logic [1:0]  rq_op  [$];
  logic        rq_err [$];

  always @(posedge clk) begin
    cyc++;
    if (dp_ld)    n_ld++;
    if (cu_start) n_start++;
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      rq_res.push_back(rsp_result);
      rq_op.push_back(rsp_op);
      rq_err.push_back(rsp_err);
    end
    if (prev_start && !cu_start)  t_fall = cyc;
    if (!prev_valid && rsp_valid) t_rise = cyc;
    prev_start = cu_start;
    prev_valid = rsp_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_res(input logic [15:0] r);
    m_res_arr[m_wr] = r;
    m_wr = m_wr + 3'd1;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    check("send_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, inout int lat);
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0, ld0, s0, t;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_dp_ld",      32'(dp_ld),      32'd0);
    check("rst_cu_start",   32'(cu_start),   32'd0);
    check("rst_cu_op",      32'(cu_op),      32'd0);
    check("rst_dp_ab",      32'({dp_a, dp_b}), 32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_fields", 32'({rsp_result, rsp_op, rsp_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Add 12+34: LOAD at negedge 0, START at 1, cu_start drops at 2, response visible at 7
    rsp_ready = 1'b1;
    push_res(16'h0046);
    b0 = n_rsp; ld0 = n_ld; s0 = n_start;
    send(2'b00, 8'h12, 8'h34);
    check("add_dp_ld",  32'(dp_ld), 32'd1);
    check("add_dp_ab",  32'({dp_a, dp_b}), 32'h1234);
    @(negedge clk);
    check("add_start",  32'(cu_start), 32'd1);
    check("add_cu_op",  32'(cu_op), 32'd0);
    check("add_ld_one", 32'(dp_ld), 32'd0);
    @(negedge clk);
    check("add_start_drop", 32'(cu_start), 32'd0);
    lat = 2;
    wait_rsp("add_rsp", lat);
    check("add_latency", 32'(lat), 32'd7);
    check("add_result", 32'(rsp_result), 32'h0046);
    check("add_op_err", 32'({rsp_op, rsp_err}), 32'd0);
    @(negedge clk);
    check("add_rsp_drop", 32'(rsp_valid), 32'd0);
    check("add_n_rsp",   32'(n_rsp - b0), 32'd1);
    check("add_n_ld",    32'(n_ld - ld0), 32'd1);
    check("add_n_start", 32'(n_start - s0), 32'd1);
    wait_idle();
    check("add_dp_hold", 32'({dp_a, dp_b}), 32'h1234);

    // Mul 5 * -3 with rsp_ready held low for 5 cycles
    rsp_ready = 1'b0;
    push_res(16'hFFF1);
    b0 = n_rsp;
    send(2'b10, 8'd5, 8'hFD);
    lat = 0;
    wait_rsp("mul_rsp", lat);
    check("mul_latency", 32'(lat), 32'd7);
    for (int i = 0; i < 5; i++) begin
      check("mul_hold_valid", 32'(rsp_valid), 32'd1);
      check("mul_hold_data", 32'({rsp_result, rsp_op, rsp_err}), 32'({16'hFFF1, 2'b10, 1'b0}));
      @(negedge clk);
    end
    check("mul_no_early", 32'(n_rsp - b0), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("mul_rsp_drop", 32'(rsp_valid), 32'd0);
    check("mul_n_rsp", 32'(n_rsp - b0), 32'd1);
    check("mul_logged", 32'(rq_res[b0]), 32'hFFF1);
    wait_idle();

    // Timeout: the unit leaves state 0 but never signals final
    m_hang = 1'b1;
    send(2'b11, 8'd7, 8'd2);
    lat = 0;
    wait_rsp("to_rsp", lat);
    check("to_err_op", 32'({rsp_op, rsp_err}), 32'b111);
    check("to_result", 32'(rsp_result), 32'd0);
    @(negedge clk);
    // One cycle in which the departure from state 0 is seen, then TO cycles of RUN.
    check("to_latency", 32'(t_rise - t_fall), 32'(TO + 1));
    m_abort = 1'b1;
    wait_idle();
    m_abort = 1'b0;
    m_hang  = 1'b0;

    // Back-to-back: second request arrives during RUN and waits for DRAIN
    m_hold = 6;
    push_res(16'h0003);
    push_res(16'h0005);
    b0 = n_rsp;
    send(2'b00, 8'd1, 8'd2);
    repeat (4) @(negedge clk);
    ld0 = n_ld;
    req_op = 2'b01; req_a = 8'd9; req_b = 8'd4; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    check("b2b_wait", 32'(t), 32'd10);
    check("b2b_first_done", 32'(n_rsp - b0), 32'd1);
    check("b2b_no_load", 32'(n_ld - ld0), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (n_rsp - b0 < 2 && t < 300) begin @(negedge clk); t++; end
    check("b2b_two_rsp", 32'(n_rsp - b0), 32'd2);
    check("b2b_order_0", 32'({rq_res[b0], rq_op[b0], rq_err[b0]}), 32'({16'h0003, 2'b00, 1'b0}));
    check("b2b_order_1", 32'({rq_res[b0+1], rq_op[b0+1], rq_err[b0+1]}), 32'({16'h0005, 2'b01, 1'b0}));
    wait_idle();
    m_hold = 0;

    // Reset during RUN
    m_hang = 1'b1;
    b0 = n_rsp;
    send(2'b10, 8'd3, 8'd4);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rrst_cu_start", 32'(cu_start), 32'd0);
    check("rrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rrst_dp_a", 32'(dp_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_hang = 1'b0;
    @(negedge clk);
    check("rrst_req_ready", 32'(req_ready), 32'd1);
    repeat (80) @(negedge clk);
    check("rrst_no_stale", 32'({n_rsp - b0, 31'(rsp_valid)}), 32'd0);

    // Recovery after reset
    push_res(16'h0110);
    send(2'b00, 8'hF0, 8'h20);
    lat = 0;
    wait_rsp("rec_rsp", lat);
    check("rec_result", 32'({rsp_result, rsp_op, rsp_err}), 32'({16'h0110, 2'b00, 1'b0}));
    wait_idle();

`ifdef ALU_SEQ_DIV0_CHECK_EN
    s0 = n_start;
    send(2'b11, 8'h55, 8'h00);
    check("div0_rsp", 32'({rsp_valid, rsp_result, rsp_op, rsp_err}), 32'({1'b1, 16'h0000, 2'b11, 1'b1}));
    @(negedge clk);
    check("div0_no_start", 32'(n_start - s0), 32'd0);
    wait_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
